// File: rtl/mem_dm_access.sv
// MEM-stage data-memory access unit: one Wishbone classic read/write per load/store,
// with byte-lane steering, load extension and a pipeline stall request.
module mem_dm_access #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  stall_req,
  output logic                  access_fault,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  logic [2:0]            r_funct3;
  logic [1:0]            r_off;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_fault;
  logic                  r_cyc;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;

  logic [1:0]            w_off;
  logic                  w_req;
  logic                  w_legal;
  logic                  w_start;
  logic                  w_fault;
  logic [3:0]            w_sel;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_off = addr[1:0];
  assign w_req = mem_read | mem_write;

  // mem_write wins when both are set, so legality follows the store table then
  always_comb begin
    w_legal = 1'b0;
    if (mem_write) begin
      case (funct3)
        3'b000:  w_legal = 1'b1;
        3'b001:  w_legal = ~w_off[0];
        3'b010:  w_legal = (w_off == 2'b00);
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b100: w_legal = 1'b1;
        3'b001, 3'b101: w_legal = ~w_off[0];
        3'b010:         w_legal = (w_off == 2'b00);
        default:        w_legal = 1'b0;
      endcase
    end
  end

  assign w_start = (r_state == S_IDLE) & w_req & w_legal;
  assign w_fault = (r_state == S_IDLE) & w_req & ~w_legal;

  always_comb begin
    w_sel = 4'b1111;
    w_dat = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_sel = 4'b0001 << w_off;
        w_dat = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_sel = w_off[1] ? 4'b1100 : 4'b0011;
        w_dat = {2{store_data[15:0]}};
      end
      default: begin
        w_sel = 4'b1111;
        w_dat = store_data;
      end
    endcase
  end

  // Extension uses the size/offset captured at issue, not the live inputs
  assign w_byte = wb_dat_i[{r_off, 3'b000} +: 8];
  assign w_half = wb_dat_i[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = wb_dat_i;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_load_data <= '0;
      r_fault     <= 1'b0;
      r_cyc       <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= 4'b0000;
      r_we        <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fault <= w_fault;
          if (w_start) begin
            r_cyc    <= 1'b1;
            r_adr    <= {addr[ADDR_WIDTH-1:2], 2'b00};
            r_dat    <= w_dat;
            r_sel    <= w_sel;
            r_we     <= mem_write;
            r_funct3 <= funct3;
            r_off    <= w_off;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (wb_ack_i) begin
            r_cyc <= 1'b0;
            if (!r_we) r_load_data <= w_ext;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_req    = w_start | (r_state == S_BUSY);
  assign access_fault = r_fault;
  assign load_data    = r_load_data;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = r_sel;
  assign wb_we_o      = r_we;

endmodule
